demo_sequencer: RTL and testbench
=================================

# demo_sequencer

Generates the demo `timer` that drives `demo_control`, and re-registers the resulting control word for the audio and video datapaths. Runs a play/pause/skip/restart state machine. Advances the timer on music step ticks. Applies host commands only at frame boundaries through a valid/ready handshake. Audio control bits update every cycle; video control bits update once per frame, so video never changes mid-frame.

## Interface
- `TIME_BITS`, 13: timer width. Pattern field is `timer[TIME_BITS-1:10]`.
- `CONTROL_BITS`, 20: control word width.
- `AUDIO_MASK`, 0: `CONTROL_BITS`-wide mask. Set bits are audio (per-cycle update); clear bits are video (per-frame update).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `step_tick` in 1: one-cycle pulse, advance timer by one step.
- `frame_start` in 1: one-cycle pulse at vblank start.
- `loop_en` in 1: wrap to 0 at end instead of stopping.
- `cmd_valid` in 1: command request.
- `cmd` in 2: 0 PLAY, 1 PAUSE, 2 SKIP, 3 RESTART.
- `cmd_ready` out 1: command can be accepted.
- `timer` out TIME_BITS: demo time, fed to `demo_control`.
- `control_in` in CONTROL_BITS: combinational control word from `demo_control(timer)`.
- `control` out CONTROL_BITS: registered control word.
- `pattern_start` out 1: one-cycle pulse when the pattern field changes.
- `running` out 1: state is RUN.
- `done` out 1: state is DONE.

## Operation
- **States:** STOP, RUN, PAUSE, DONE.
  - Reset enters STOP with `timer`=0.
- **Ticks:** in RUN, `step_tick` increments `timer`. In STOP, PAUSE and DONE, ticks are ignored.
- **End of timer:** a tick in RUN at `timer` = all ones:
  - `loop_en`=1: `timer` wraps to 0 and state stays RUN.
  - `loop_en`=0: state goes to DONE and `timer` holds at all ones.
- **Command handshake:**
  - A command is accepted when `cmd_valid && cmd_ready`.
  - It is stored as pending, and `cmd_ready` is 0 while pending.
  - The pending command is applied on the first `frame_start` cycle strictly after the accept cycle.
- **Command effects when applied:**
  - PLAY: STOP→RUN and PAUSE→RUN. In DONE, `timer`←0 and state→RUN. In RUN, no effect.
  - PAUSE: RUN→PAUSE; no effect in any other state.
  - SKIP: `timer` ← (pattern+1)<<10 with low 10 bits cleared; state unchanged.
    - If the pattern is already the last one: `loop_en`=1 gives `timer`←0; `loop_en`=0 gives state→DONE and `timer`←all ones.
    - In DONE, SKIP has no effect.
  - RESTART: `timer`←0 and state→RUN, from any state.
- **Collisions:** in the apply cycle, `step_tick` is dropped; the command wins.
- **Control register:**
  - Bits with `AUDIO_MASK`=1 load `control_in` every cycle.
  - Bits with `AUDIO_MASK`=0 load `control_in` only in the cycle after `frame_start` (`frame_start` delayed 1). Video therefore sees the timer value after any command applied at `frame_start`.
- **pattern_start:** asserted for one cycle whenever the registered pattern field differs from its value one cycle earlier. This covers ticks, wrap, SKIP, RESTART, and PLAY from DONE.
- **Reset:** asynchronous, at any time, including with a command pending. Pending command is discarded; `timer`=0; state STOP; `control`=0; `pattern_start`=0; `cmd_ready`=1; `running`=0; `done`=0.

## Timing
- `timer` changes on the edge ending the `step_tick` or apply cycle. `control_in` is valid combinationally in the next cycle.
- Audio bits of `control` lag `timer` by 1 cycle.
- Video bits of `control` update on the edge ending cycle F+1, where F is the `frame_start` cycle. They hold for the rest of the frame.
- `cmd_ready`:
  - Falls on the edge after the accept cycle.
  - Rises on the edge ending the apply cycle, so it is high in the cycle after apply.
  - A `frame_start` in the accept cycle itself does not apply the command.
- `pattern_start` is high in the cycle after `timer`'s pattern field changes.
- `running` and `done` are registered state decodes with no extra lag versus the state.

## Test plan
- **Reset and tick gating:** assert `reset` mid-run → all outputs at reset values, `cmd_ready`=1. Then 5 `step_tick` pulses in STOP → `timer` stays 0.
- **Run and pattern boundary:** PLAY applied at a `frame_start`, then 1024 ticks → `timer`=0x400, `pattern_start` high for exactly one cycle. PAUSE applied → further ticks leave `timer` at 0x400, `running`=0.
- **Frame-aligned skip:** at `timer`=0x123, accept SKIP; hold `frame_start` low for 50 cycles → `timer` stays 0x123, `cmd_ready`=0. Pulse `frame_start` together with `step_tick` → `timer`=0x400 (tick dropped), `pattern_start` pulse, `cmd_ready`=1 one cycle later.
- **End behaviour:** `timer`=0x1FFF plus a tick:
  - `loop_en`=0 → DONE, `done`=1, `timer`=0x1FFF.
  - `loop_en`=1 → `timer`=0, `pattern_start` pulse, stays RUN.
  - From DONE, PLAY → `timer`=0, RUN.
- **Control latching:** `AUDIO_MASK`=0x00001. Change `control_in` from 0x00000 to 0xFFFFF mid-frame → `control`=0x00001 next cycle. Bits 19:1 become 1 only in the cycle after the next `frame_start` + 1.
- **Reset with pending command:** accept RESTART, assert `reset` before `frame_start` → no command applied afterward, state STOP, `cmd_ready`=1.

Source files
------------

// File: rtl/demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demo_sequencer
// Brief    : Play/pause/skip/restart demo timer with frame-aligned commands
//            and audio (per-cycle) / video (per-frame) control re-registering.
// Revision : 1.0 - initial release
// ============================================================================
module demo_sequencer #(
    parameter int                      TIME_BITS    = 13,
    parameter int                      CONTROL_BITS = 20,
    parameter logic [CONTROL_BITS-1:0] AUDIO_MASK   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_tick,
    input  logic                    frame_start,
    input  logic                    loop_en,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd,
    output logic                    cmd_ready,
    output logic [TIME_BITS-1:0]    timer,
    input  logic [CONTROL_BITS-1:0] control_in,
    output logic [CONTROL_BITS-1:0] control,
    output logic                    pattern_start,
    output logic                    running,
    output logic                    done
);

    localparam int         c_pat_bits = TIME_BITS - 10;
    localparam logic [1:0] c_cmd_play    = 2'd0;
    localparam logic [1:0] c_cmd_pause   = 2'd1;
    localparam logic [1:0] c_cmd_skip    = 2'd2;
    localparam logic [1:0] c_cmd_restart = 2'd3;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [TIME_BITS-1:0]    r_timer;
    logic                    r_pending;
    logic [1:0]              r_cmd;
    logic                    r_frame_d;
    logic [CONTROL_BITS-1:0] r_control;
    logic                    r_pattern_start;
    logic                    r_running;
    logic                    r_done;

    state_t                  w_state_next;
    logic [TIME_BITS-1:0]    w_timer_next;
    logic                    w_apply;
    logic [c_pat_bits-1:0]   w_pat;
    logic [c_pat_bits-1:0]   w_pat_inc;
    logic [CONTROL_BITS-1:0] w_control_next;

    assign w_apply   = r_pending && frame_start;
    assign w_pat     = r_timer[TIME_BITS-1:10];
    assign w_pat_inc = w_pat + {{(c_pat_bits-1){1'b0}}, 1'b1};

    // An applied command always wins over a coincident step tick.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        if (w_apply) begin
            case (r_cmd)
                c_cmd_play: begin
                    if (r_state == ST_DONE) begin
                        w_timer_next = '0;
                    end
                    w_state_next = ST_RUN;
                end
                c_cmd_pause: begin
                    if (r_state == ST_RUN) begin
                        w_state_next = ST_PAUSE;
                    end
                end
                c_cmd_skip: begin
                    if (r_state != ST_DONE) begin
                        if (&w_pat) begin
                            if (loop_en) begin
                                w_timer_next = '0;
                            end else begin
                                w_timer_next = '1;
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_timer_next = {w_pat_inc, 10'd0};
                        end
                    end
                end
                default: begin
                    w_timer_next = '0;
                    w_state_next = ST_RUN;
                end
            endcase
        end else if (step_tick && (r_state == ST_RUN)) begin
            if (&r_timer) begin
                if (loop_en) begin
                    w_timer_next = '0;
                end else begin
                    w_state_next = ST_DONE;
                end
            end else begin
                w_timer_next = r_timer + {{(TIME_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Video bits load only in the cycle after frame_start, audio bits always.
    assign w_control_next = r_frame_d ? control_in
                          : ((control_in & AUDIO_MASK) | (r_control & ~AUDIO_MASK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_STOP;
            r_timer         <= '0;
            r_pending       <= 1'b0;
            r_cmd           <= 2'd0;
            r_frame_d       <= 1'b0;
            r_control       <= '0;
            r_pattern_start <= 1'b0;
            r_running       <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_timer         <= w_timer_next;
            r_running       <= (w_state_next == ST_RUN);
            r_done          <= (w_state_next == ST_DONE);
            r_pattern_start <= (w_timer_next[TIME_BITS-1:10] != w_pat);
            r_frame_d       <= frame_start;
            r_control       <= w_control_next;
            if (w_apply) begin
                r_pending <= 1'b0;
            end else if (cmd_valid && !r_pending) begin
                r_pending <= 1'b1;
                r_cmd     <= cmd;
            end
        end
    end

    assign cmd_ready     = !r_pending;
    assign timer         = r_timer;
    assign control       = r_control;
    assign pattern_start = r_pattern_start;
    assign running       = r_running;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demo_sequencer
// Brief    : Vector table, directed corner sequences and random stimulus
//            against a behavioural model of demo_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demo_sequencer;

    localparam int             TB = 13;
    localparam int             CB = 20;
    localparam logic [CB-1:0]  MASK = 20'h00001;
    localparam int             S_STOP = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic step_tick = 1'b0, frame_start = 1'b0, loop_en = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic cmd_ready, pattern_start, running, done;
    logic [TB-1:0] timer;
    logic [CB-1:0] control_in, control;
    logic [CB-1:0] ctl_drv = '0;
    logic ctl_mode = 1'b0;

    int n_chk = 0, n_bad = 0, ps_count = 0;

    int m_state, m_timer, m_cmd;
    bit m_pend, m_fd, m_ps;
    logic [CB-1:0] m_control;

    typedef struct {
        logic step, frame, valid;
        logic [1:0] c;
        logic [TB-1:0] t;
        logic rdy, run, dn, ps;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [CB-1:0] ctl_fn(input logic [TB-1:0] t);
        return {t[6:0], t} ^ 20'h5A5A5;
    endfunction

    assign control_in = ctl_mode ? ctl_fn(timer) : ctl_drv;

    always #5 clk = ~clk;

    demo_sequencer #(.TIME_BITS(TB), .CONTROL_BITS(CB), .AUDIO_MASK(MASK)) dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .frame_start(frame_start),
        .loop_en(loop_en), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .timer(timer), .control_in(control_in), .control(control),
        .pattern_start(pattern_start), .running(running), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_STOP; m_timer = 0; m_cmd = 0;
        m_pend = 1'b0; m_fd = 1'b0; m_ps = 1'b0; m_control = '0;
    endtask

    // One clock of the behavioural model, from the inputs currently driven.
    task automatic model_edge();
        int nt, ns;
        bit apply;
        logic [CB-1:0] cin;
        nt = m_timer; ns = m_state;
        apply = m_pend && frame_start;
        if (apply) begin
            case (m_cmd)
                0: begin if (m_state == S_DONE) nt = 0; ns = S_RUN; end
                1: if (m_state == S_RUN) ns = S_PAUSE;
                2: if (m_state != S_DONE) begin
                       if (m_timer / 1024 == 7) begin
                           if (loop_en) nt = 0; else begin nt = 8191; ns = S_DONE; end
                       end else nt = (m_timer / 1024 + 1) * 1024;
                   end
                default: begin nt = 0; ns = S_RUN; end
            endcase
        end else if (step_tick && m_state == S_RUN) begin
            if (m_timer == 8191) begin
                if (loop_en) nt = 0; else ns = S_DONE;
            end else nt = m_timer + 1;
        end
        m_ps = (nt / 1024) != (m_timer / 1024);
        cin = ctl_mode ? ctl_fn(TB'(m_timer)) : ctl_drv;
        m_control = m_fd ? cin : ((cin & MASK) | (m_control & ~MASK));
        m_fd = frame_start;
        if (apply) m_pend = 1'b0;
        else if (cmd_valid && !m_pend) begin m_pend = 1'b1; m_cmd = int'(cmd); end
        m_timer = nt; m_state = ns;
    endtask

    task automatic check_all();
        check("timer", 32'(timer), m_timer);
        check("cmd_ready", 32'(cmd_ready), 32'(!m_pend));
        check("running", 32'(running), 32'(m_state == S_RUN));
        check("done", 32'(done), 32'(m_state == S_DONE));
        check("pattern_start", 32'(pattern_start), 32'(m_ps));
        check("control", 32'(control), 32'(m_control));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (pattern_start) ps_count++;
        check_all();
    endtask

    // Reset asserted mid-cycle, checked before the next edge arrives.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check("rst_timer", 32'(timer), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pstart", 32'(pattern_start), 0);
        check("rst_control", 32'(control), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1; cmd = c;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic tick(input int n);
        step_tick = 1'b1;
        repeat (n) cycle();
        step_tick = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h001, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h002, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd2, 13'h003, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 13'h400, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h401, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 13'h401, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 13'h401, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h401, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd3, 13'h401, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 1'b0, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step_tick = tbl[i].step; frame_start = tbl[i].frame;
            cmd_valid = tbl[i].valid; cmd = tbl[i].c;
            cycle();
            check($sformatf("vec%0d_timer", i), 32'(timer), 32'(tbl[i].t));
            check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].run));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].dn));
            check($sformatf("vec%0d_pstart", i), 32'(pattern_start), 32'(tbl[i].ps));
        end
        step_tick = 1'b0; frame_start = 1'b0; cmd_valid = 1'b0;

        // Reset mid-run, then ticks in STOP are ignored
        do_reset();
        tick(5);
        check("stop_ticks_timer", 32'(timer), 0);

        // Run across the first pattern boundary, then pause
        send_cmd(2'd0);
        ps_count = 0;
        tick(1024);
        check("run_timer", 32'(timer), 32'h400);
        check("run_pstart_count", 32'(ps_count), 1);
        send_cmd(2'd1);
        tick(5);
        check("pause_timer", 32'(timer), 32'h400);
        check("pause_running", 32'(running), 0);

        // Skip held pending until a frame boundary, tick dropped on apply
        do_reset();
        send_cmd(2'd0);
        tick(13'h123);
        cmd_valid = 1'b1; cmd = 2'd2;
        cycle();
        cmd_valid = 1'b0;
        repeat (50) cycle();
        check("skip_wait_timer", 32'(timer), 32'h123);
        check("skip_wait_ready", 32'(cmd_ready), 0);
        frame_start = 1'b1; step_tick = 1'b1;
        cycle();
        frame_start = 1'b0; step_tick = 1'b0;
        check("skip_timer", 32'(timer), 32'h400);
        check("skip_pstart", 32'(pattern_start), 1);
        check("skip_ready", 32'(cmd_ready), 1);

        // End of timer: stop in DONE, replay, then wrap with loop_en
        do_reset();
        send_cmd(2'd0);
        repeat (7) send_cmd(2'd2);
        check("end_skip7_timer", 32'(timer), 32'h1C00);
        tick(1023);
        check("end_pre_timer", 32'(timer), 32'h1FFF);
        loop_en = 1'b0;
        tick(1);
        check("end_done", 32'(done), 1);
        check("end_timer_hold", 32'(timer), 32'h1FFF);
        tick(3);
        check("end_done_ticks", 32'(timer), 32'h1FFF);
        send_cmd(2'd0);
        check("replay_timer", 32'(timer), 0);
        check("replay_running", 32'(running), 1);
        repeat (7) send_cmd(2'd2);
        tick(1023);
        loop_en = 1'b1;
        tick(1);
        check("wrap_timer", 32'(timer), 0);
        check("wrap_pstart", 32'(pattern_start), 1);
        check("wrap_running", 32'(running), 1);
        loop_en = 1'b0;

        // Audio bit follows immediately, video bits wait for frame_start + 1
        ctl_drv = '0;
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        repeat (3) cycle();
        check("ctl_zero", 32'(control), 0);
        ctl_drv = 20'hFFFFF;
        cycle();
        check("ctl_audio", 32'(control), 32'h00001);
        repeat (3) cycle();
        check("ctl_hold", 32'(control), 32'h00001);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        check("ctl_frame_cycle", 32'(control), 32'h00001);
        cycle();
        check("ctl_video", 32'(control), 32'hFFFFF);

        // Reset discards a pending command
        do_reset();
        cmd_valid = 1'b1; cmd = 2'd3;
        cycle();
        cmd_valid = 1'b0;
        check("pend_ready_low", 32'(cmd_ready), 0);
        do_reset();
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        cycle();
        check("pend_discard_running", 32'(running), 0);
        check("pend_discard_timer", 32'(timer), 0);
        check("pend_discard_ready", 32'(cmd_ready), 1);

        // Random traffic against the model
        ctl_mode = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step_tick   = ($urandom_range(0, 1) == 1);
                frame_start = ($urandom_range(0, 15) == 0);
                cmd_valid   = ($urandom_range(0, 5) == 0);
                cmd         = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
